// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: FSM states, Gray-order
// constants and the transition classifier used by the decode stage.
package quad_pkg;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } quad_state_e;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_FWD  = 2'd1,
    TR_REV  = 2'd2,
    TR_ILL  = 2'd3
  } quad_tr_e;

  // Forward rotation visits these states in the order 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  // Classify a {prev,new} pair of filtered {A,B} values.
  function automatic quad_tr_e quad_classify(input logic [1:0] prev_ab,
                                             input logic [1:0] new_ab);
    quad_tr_e tr;
    tr = TR_ILL;
    if (prev_ab == new_ab) begin
      tr = TR_NONE;
    end else begin
      case (prev_ab)
        QS_00:   tr = (new_ab == QS_01) ? TR_FWD : ((new_ab == QS_10) ? TR_REV : TR_ILL);
        QS_01:   tr = (new_ab == QS_11) ? TR_FWD : ((new_ab == QS_00) ? TR_REV : TR_ILL);
        QS_11:   tr = (new_ab == QS_10) ? TR_FWD : ((new_ab == QS_01) ? TR_REV : TR_ILL);
        QS_10:   tr = (new_ab == QS_00) ? TR_FWD : ((new_ab == QS_11) ? TR_REV : TR_ILL);
        default: tr = TR_ILL;
      endcase
    end
    return tr;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: flop-chain synchroniser followed by a stability
// counter. A change on the synchronised input is accepted only after it has
// held for FILT_LEN consecutive cycles. load_i forces the filtered value to
// the current synchroniser output (used once when decoding starts).
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  input  logic load_i,
  output logic sync_o,
  output logic filt_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   filt_q;
  logic                   filt_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign sync_o = sync_s;
  assign filt_o = filt_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

  // Stability counter: restart on agreement, accept after FILT_LEN mismatches.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      filt_d = sync_s;
      cnt_d  = '0;
    end else if (sync_s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync_s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Register filtered value and stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature-encoder front end: synchronise and filter A/B, decode Gray
// transitions into a one-cycle step pulse plus direction level, and count
// illegal double-bit transitions in a saturating counter.
// Build option: QUAD_X4_EN defined -> step on every legal transition;
// undefined -> step only when entering state 00 (one count per cycle).
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear_err,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       ab_state
);

  localparam int INIT_CYC = SYNC_STAGES + FILT_LEN;
  localparam int INIT_W   = $clog2(INIT_CYC + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

  quad_state_e      state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       ab_q, ab_d;

  logic             load_s;
  logic             a_sync_s, b_sync_s;
  logic             a_filt_s, b_filt_s;
  logic [1:0]       filt_ab_s;
  logic             step_gate_s;
  quad_tr_e         tr_s;

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (a_in),
    .load_i (load_s),
    .sync_o (a_sync_s),
    .filt_o (a_filt_s)
  );

  quad_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (b_in),
    .load_i (load_s),
    .sync_o (b_sync_s),
    .filt_o (b_filt_s)
  );

  assign filt_ab_s = {a_filt_s, b_filt_s};
  assign tr_s      = quad_classify(ab_q, filt_ab_s);

`ifdef QUAD_X4_EN
  assign step_gate_s = 1'b1;
`else
  assign step_gate_s = (filt_ab_s == QS_00);
`endif

  // FSM next state, start-up load and Gray decode.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    load_s     = 1'b0;
    step_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    ab_d       = ab_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          load_s     = 1'b1;
          ab_d       = {a_sync_s, b_sync_s};
          init_cnt_d = '0;
          state_d    = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_ONE;
        end
      end
      S_RUN: begin
        ab_d = filt_ab_s;
        case (tr_s)
          TR_FWD: begin
            dir_d  = 1'b1;
            step_d = step_gate_s;
          end
          TR_REV: begin
            dir_d  = 1'b0;
            step_d = step_gate_s;
          end
          TR_ILL:  err_d = 1'b1;
          TR_NONE: err_d = 1'b0;
          default: err_d = 1'b0;
        endcase
      end
      default: begin
        state_d    = S_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // Saturating error count; a clear wins over a same-cycle error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear_err) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      ab_q       <= QS_00;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      ab_q       <= ab_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;
  assign ab_state  = ab_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random A/B traffic,
// all checked every cycle against a run-length / Gray-position model.
module tb_quad_step_decoder;

  localparam int S = 2;
  localparam int F = 4;
`ifdef QUAD_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_in, b_in, clear_err;
  logic       step0, dir0, err0;
  logic [7:0] cnt0;
  logic [1:0] ab0;
  logic       step1, dir1, err1;
  logic [1:0] cnt1;
  logic [1:0] ab1;

  quad_step_decoder #(.SYNC_STAGES(S), .FILT_LEN(F), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clear_err(clear_err),
    .step(step0), .dir(dir0), .err(err0), .err_count(cnt0), .ab_state(ab0)
  );

  quad_step_decoder #(.SYNC_STAGES(S), .FILT_LEN(F), .ERR_W(2)) u_dut_e2 (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clear_err(clear_err),
    .step(step1), .dir(dir1), .err(err1), .err_count(cnt1), .ab_state(ab1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_t;
  bit       qa[$], qb[$];     // raw inputs sampled at each edge since reset
  bit       sa[$], sb[$];     // synchroniser outputs seen at each edge
  bit       mf_a, mf_b;
  bit [1:0] m_ab;
  bit       m_step, m_dir, m_err;
  int       m_cnt8, m_cnt2;
  int       pos_of [4] = '{0, 1, 3, 2};  // Gray position of 00,01,10,11

  task automatic model_reset();
    m_t = 0;
    qa.delete(); qb.delete(); sa.delete(); sb.delete();
    mf_a = 1'b0; mf_b = 1'b0; m_ab = 2'b00;
    m_step = 1'b0; m_dir = 1'b1; m_err = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_edge(input bit a, input bit b, input bit clr);
    bit sya, syb, fl_a, fl_b;
    bit [1:0] nw;
    int d;
    m_t++;
    sya = (m_t - S >= 1) ? qa[m_t-S-1] : 1'b0;
    syb = (m_t - S >= 1) ? qb[m_t-S-1] : 1'b0;
    sa.push_back(sya);
    sb.push_back(syb);
    m_step = 1'b0;
    m_err  = 1'b0;
    if (m_t == S + F) begin
      mf_a = sya; mf_b = syb; m_ab = {sya, syb};
    end else begin
      if (m_t > S + F) begin
        nw = {mf_a, mf_b};
        d = (pos_of[nw] - pos_of[m_ab] + 4) % 4;
        if (d == 1) begin m_dir = 1'b1; m_step = X4 || (nw == 2'b00); end
        if (d == 3) begin m_dir = 1'b0; m_step = X4 || (nw == 2'b00); end
        if (d == 2) m_err = 1'b1;
        m_ab = nw;
      end
      // a channel flips once its last F synchronised samples all disagree
      fl_a = (sa.size() >= F);
      fl_b = (sb.size() >= F);
      for (int k = 0; k < F; k++) begin
        if (fl_a && sa[sa.size()-1-k] == mf_a) fl_a = 1'b0;
        if (fl_b && sb[sb.size()-1-k] == mf_b) fl_b = 1'b0;
      end
      mf_a = mf_a ^ fl_a;
      mf_b = mf_b ^ fl_b;
    end
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    qa.push_back(a);
    qb.push_back(b);
  endtask

  task automatic compare_all();
    check_eq("step",   step0, m_step);
    check_eq("dir",    dir0,  m_dir);
    check_eq("err",    err0,  m_err);
    check_eq("errcnt", cnt0,  m_cnt8);
    check_eq("ab",     ab0,   m_ab);
    check_eq("step_e2",   step1, m_step);
    check_eq("dir_e2",    dir1,  m_dir);
    check_eq("err_e2",    err1,  m_err);
    check_eq("errcnt_e2", cnt1,  m_cnt2);
    check_eq("ab_e2",     ab1,   m_ab);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_step"}, step0, 1'b0);
    check_eq({tag, "_dir"},  dir0,  1'b1);
    check_eq({tag, "_err"},  err0,  1'b0);
    check_eq({tag, "_cnt"},  cnt0,  8'd0);
    check_eq({tag, "_ab"},   ab0,   2'b00);
    check_eq({tag, "_cnt_e2"}, cnt1, 2'd0);
  endtask

  // one clock: drive inputs, advance model at the edge, compare at negedge
  task automatic cyc(input bit a, input bit b, input bit clr);
    a_in = a; b_in = b; clear_err = clr;
    @(posedge clk);
    model_edge(a, b, clr);
    @(negedge clk);
    cyc_n++;
    compare_all();
  endtask

  // hold {A,B} for n cycles, reporting step/err pulses and first step offset
  task automatic seg(input logic [1:0] ab, input int n, input int clr_at,
                     output int steps, output int errs, output int first_at);
    steps = 0; errs = 0; first_at = -1;
    for (int i = 1; i <= n; i++) begin
      cyc(ab[1], ab[0], (i == clr_at));
      if (step0) begin
        steps++;
        if (first_at < 0) first_at = i;
      end
      if (err0) errs++;
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  initial begin
    int st, er, fa, exp_st;
    logic [1:0] cur, nxt;
    rst_n = 1'b0; a_in = 1'b0; b_in = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // 1: idle after reset
    seg(2'b00, 10, 0, st, er, fa);
    check_eq("idle_steps", st, 0);
    check_eq("idle_errs", er, 0);

    // 2: forward rotation, one step per transition (x4) or per cycle (x1)
    for (int k = 0; k < 4; k++) begin
      seg(fwd_seq[k], 10, 0, st, er, fa);
      exp_st = (X4 || fwd_seq[k] == 2'b00) ? 1 : 0;
      check_eq("fwd_steps", st, exp_st);
      check_eq("fwd_lat", fa, (exp_st == 1) ? 7 : -1);
      check_eq("fwd_dir", dir0, 1'b1);
    end

    // 3: reverse rotation, dir drops from the first transition
    for (int k = 0; k < 4; k++) begin
      seg(rev_seq[k], 10, 0, st, er, fa);
      exp_st = (X4 || rev_seq[k] == 2'b00) ? 1 : 0;
      check_eq("rev_steps", st, exp_st);
      check_eq("rev_lat", fa, (exp_st == 1) ? 7 : -1);
      check_eq("rev_dir", dir0, 1'b0);
    end

    // 4: 3-cycle glitch on A is filtered out
    seg(2'b10, 3, 0, st, er, fa);
    seg(2'b00, 10, 0, st, er, fa);
    check_eq("glitch_steps", st, 0);
    check_eq("glitch_errs", er, 0);
    check_eq("glitch_ab", ab0, 2'b00);

    // 5: double-bit transitions, saturation and clear priority
    seg(2'b11, 10, 0, st, er, fa);
    check_eq("ill_errs", er, 1);
    check_eq("ill_steps", st, 0);
    check_eq("ill_cnt", cnt0, 8'd1);
    check_eq("ill_ab", ab0, 2'b11);
    check_eq("ill_dir", dir0, 1'b0);
    for (int k = 0; k < 4; k++) seg((k % 2 == 0) ? 2'b00 : 2'b11, 10, 0, st, er, fa);
    check_eq("sat_cnt8", cnt0, 8'd5);
    check_eq("sat_cnt2", cnt1, 2'd3);
    seg(2'b00, 10, 7, st, er, fa);
    check_eq("clr_errs", er, 1);
    check_eq("clr_cnt8", cnt0, 8'd0);
    check_eq("clr_cnt2", cnt1, 2'd0);

    // 6: reset while a step is in flight
    seg(2'b01, 10, 0, st, er, fa);
    seg(2'b11, 3, 0, st, er, fa);
    pulse_reset("midrst");
    seg(2'b11, 12, 0, st, er, fa);
    check_eq("post_rst_steps", st, 0);
    check_eq("post_rst_errs", er, 0);
    check_eq("post_rst_ab", ab0, 2'b11);
    check_eq("post_rst_dir", dir0, 1'b1);

    // random traffic: mixed hold lengths, illegal jumps, clears and resets
    cur = 2'b11;
    for (int r = 0; r < 400; r++) begin
      case ($urandom_range(0, 9))
        0:       nxt = ~cur;
        1:       nxt = 2'($urandom_range(0, 3));
        2, 3, 4: nxt = {cur[0], ~cur[1]};   // forward neighbour
        default: nxt = {~cur[0], cur[1]};   // reverse neighbour
      endcase
      cur = nxt;
      for (int i = $urandom_range(1, 12); i > 0; i--) begin
        cyc(cur[1], cur[0], ($urandom_range(0, 15) == 0));
      end
      if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
